// File: rtl/brent_kung_pipe_adder.sv
// brent_kung_pipe_adder
//   Pipelined Brent-Kung prefix adder/subtractor with a valid/ready handshake.
//   Computes {cout,sum} = a + (sub ? ~b : b) + (cin ^ sub). ovf is the signed
//   overflow, i.e. the carry into the MSB xor the carry out of the MSB.
//   Latency is STAGES cycles when the pipe is not stalled, and the pipe
//   sustains one result per cycle. Bubbles collapse under backpressure.
//
//   Register placement by STAGES:
//     1: output only
//     2: adds a register after the up-sweep
//     3: adds a register after g/p generate
//     4: adds an input capture register
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready    operand handshake
//   a, b, cin, sub        operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid, out_ready  result handshake
//   sum, cout, ovf        result mod 2^N, carry-out (sub: 1 = no borrow),
//                         signed overflow
module brent_kung_pipe_adder #(
  parameter int N      = 64,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int LG = $clog2(N);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] bb;
    logic         c0;
  } raw_t;

  // p0 is the bitwise propagate that the final sum XOR needs.
  // g and p are the in-place prefix tree values.
  typedef struct packed {
    logic [N-1:0] p0;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic         c0;
  } gp_t;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  // The carry-in is folded into bit 0's generate term. After the prefix pass,
  // g[i] is therefore the carry out of bit i.
  function automatic gp_t f_gen(raw_t r);
    gp_t y;
    y.p0 = r.a ^ r.bb;
    y.p  = y.p0;
    y.g  = r.a & r.bb;
    y.g[0] = y.g[0] | (y.p0[0] & r.c0);
    y.c0 = r.c0;
    return y;
  endfunction

  // Up-sweep: level l combines the span ending at i with the span ending at
  // i - 2^l, for every i = k*2^(l+1) - 1.
  function automatic gp_t f_up(gp_t x);
    gp_t y;
    y = x;
    for (int l = 0; l < LG; l++)
      for (int i = (2 << l) - 1; i < N; i += (2 << l)) begin
        y.g[i] = y.g[i] | (y.p[i] & y.g[i-(1<<l)]);
        y.p[i] = y.p[i] & y.p[i-(1<<l)];
      end
    return y;
  endfunction

  // Down-sweep fills in the remaining prefix positions. It then forms the
  // sum, cout and ovf outputs.
  function automatic res_t f_down(gp_t x);
    gp_t  y;
    res_t r;
    y = x;
    for (int l = LG - 2; l >= 0; l--)
      for (int i = 3 * (1 << l) - 1; i < N; i += (2 << l)) begin
        y.g[i] = y.g[i] | (y.p[i] & y.g[i-(1<<l)]);
        y.p[i] = y.p[i] & y.p[i-(1<<l)];
      end
    r.sum  = y.p0 ^ {y.g[N-2:0], y.c0};
    r.cout = y.g[N-1];
    r.ovf  = y.g[N-1] ^ y.g[N-2];
    return r;
  endfunction

  // Valid chain. Register k loads when it is empty or its contents move on.
  // A level can move on if any later level is empty or out_ready is high.
  logic [STAGES:1] vq, en, ld;
  logic [STAGES:0] vld_pipe;
  logic            room;

  assign vld_pipe = {vq, in_valid};

  always_comb begin
    room = out_ready;
    en   = '0;
    ld   = '0;
    for (int k = STAGES; k >= 1; k--) begin
      room  = room | ~vld_pipe[k];
      en[k] = room;
      ld[k] = room & vld_pipe[k-1];
    end
  end

  assign in_ready  = en[1];
  assign out_valid = vq[STAGES];

  always_ff @(posedge clk or posedge rst)
    if (rst) vq <= '0;
    else
      for (int k = 1; k <= STAGES; k++)
        if (en[k]) vq[k] <= vld_pipe[k-1];

  // Datapath. Data registers load only with a valid word. Idle inputs
  // therefore never disturb held state.
  raw_t raw_d, raw_q;
  gp_t  gp_d, gp_q, up_d, up_q;
  res_t res_d, res_q;

  assign raw_d = {a, (sub ? ~b : b), (cin ^ sub)};

  if (STAGES >= 4) begin : g_in_reg
    always_ff @(posedge clk or posedge rst)
      if (rst)        raw_q <= '0;
      else if (ld[1]) raw_q <= raw_d;
  end else begin : g_in_pass
    assign raw_q = raw_d;
  end

  assign gp_d = f_gen(raw_q);

  if (STAGES >= 3) begin : g_gp_reg
    always_ff @(posedge clk or posedge rst)
      if (rst)               gp_q <= '0;
      else if (ld[STAGES-2]) gp_q <= gp_d;
  end else begin : g_gp_pass
    assign gp_q = gp_d;
  end

  assign up_d = f_up(gp_q);

  if (STAGES >= 2) begin : g_up_reg
    always_ff @(posedge clk or posedge rst)
      if (rst)               up_q <= '0;
      else if (ld[STAGES-1]) up_q <= up_d;
  end else begin : g_up_pass
    assign up_q = up_d;
  end

  assign res_d = f_down(up_q);

  always_ff @(posedge clk or posedge rst)
    if (rst)             res_q <= '0;
    else if (ld[STAGES]) res_q <= res_d;

  assign sum  = res_q.sum;
  assign cout = res_q.cout;
  assign ovf  = res_q.ovf;

endmodule

// File: tb/tb_brent_kung_pipe_adder.sv
// Testbench for brent_kung_pipe_adder.
// Instance 0 is N=8, STAGES=2, driven with directed vectors and then random
// ones. Instances 1..4 are N=64 with STAGES 1..4, driven with random and
// corner operands. Each instance has its own scoreboard queue. Stimulus
// pushes the expected result on accept. A negedge monitor pops and compares
// whenever out_valid && out_ready.
module tb_brent_kung_pipe_adder;
  int checks = 0;
  int errors = 0;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] done;

  localparam int NR = 3000;   // full-rate random ops per instance
  localparam int NB = 3000;   // backpressure random ops per instance

  for (genvar gi = 0; gi < 5; gi++) begin : g_inst
    localparam int W = (gi == 0) ? 8 : 64;
    localparam int S = (gi == 0) ? 2 : gi;

    typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           tacc;
      bit           lat;
    } exp_t;
    exp_t q[$];

    logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum, e_sum;
    logic e_cout, e_ovf, e_lat;
    int cyc = 0;
    bit fin = 1'b0;
    assign done[gi] = fin;

    brent_kung_pipe_adder #(.N(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain (W+1)-bit arithmetic. Signed overflow occurs when both
    // addends share a sign and the result's sign differs from it.
    task automatic set_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s);
      logic [W-1:0] bb;
      logic [W:0]   t;
      a = x; b = y; cin = ci; sub = s;
      bb = s ? ~y : y;
      t = {1'b0, x} + {1'b0, bb} + {{W{1'b0}}, ci ^ s};
      e_sum  = t[W-1:0];
      e_cout = t[W];
      e_ovf  = (x[W-1] == bb[W-1]) && (t[W-1] != x[W-1]);
    endtask

    function automatic logic [W-1:0] rv();
      logic [63:0]  r;
      logic [W-1:0] m;
      r = {$urandom(), $urandom()};
      m = '0;
      case ($urandom_range(0, 9))
        0: m = '0;
        1: m = '1;
        2: m[W-1] = 1'b1;
        3: begin m = '1; m[W-1] = 1'b0; end
        4: m = {{(W-1){1'b0}}, 1'b1};
        default: m = r[W-1:0];
      endcase
      return m;
    endfunction

    task automatic rnd_op();
      set_op(rv(), rv(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Hold the current operands until they are accepted (bounded wait).
    task automatic send(input bit bp);
      bit acc;
      acc = 1'b0;
      for (int t = 0; t < 2000 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        if (bp) out_ready = ($urandom_range(0, 9) >= 3);
      end
      if (!acc) begin
        errors++;
        $display("FAIL accept_timeout inst=%0d got in_ready=0 want 1", gi);
      end
    endtask

    // Monitor / scoreboard
    initial begin : mon
      exp_t e;
      bit pst;
      logic [W-1:0] psum;
      logic pcout, povf;
      pst = 1'b0; psum = '0; pcout = 1'b0; povf = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin pst = 1'b0; continue; end
        checks++;
        if (in_ready !== ((q.size() < S) || out_ready)) begin
          errors++;
          $display("FAIL in_ready inst=%0d got %b want %b (inflight=%0d out_ready=%b)",
                   gi, in_ready, (q.size() < S) || out_ready, q.size(), out_ready);
        end
        if (pst) begin
          checks++;
          if (out_valid !== 1'b1 || sum !== psum || cout !== pcout || ovf !== povf) begin
            errors++;
            $display("FAIL stall_hold inst=%0d got v=%b sum=%h c=%b o=%b want v=1 sum=%h c=%b o=%b",
                     gi, out_valid, sum, cout, ovf, psum, pcout, povf);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL spurious inst=%0d got out_valid=1 sum=%h want no result", gi, sum);
          end else begin
            e = q.pop_front();
            if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
              errors++;
              $display("FAIL result inst=%0d got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                       gi, sum, cout, ovf, e.sum, e.cout, e.ovf);
            end
            if (e.lat) begin
              checks++;
              if (cyc - e.tacc != S) begin
                errors++;
                $display("FAIL latency inst=%0d got %0d want %0d", gi, cyc - e.tacc, S);
              end
            end
          end
        end
        pst = out_valid && !out_ready;
        psum = sum; pcout = cout; povf = ovf;
        if (in_valid && in_ready)
          q.push_back('{sum: e_sum, cout: e_cout, ovf: e_ovf, tacc: cyc, lat: e_lat});
      end
    end

    // Stimulus
    initial begin : stim
      int da[9] = '{0, 255, 255, 255, 5, 3, 0, 127, 128};
      int db[9] = '{0, 0, 255, 255, 3, 5, 0, 1, 1};
      int dc[9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
      int ds[9] = '{0, 0, 0, 0, 1, 1, 1, 0, 1};
      int es[9] = '{0, 255, 254, 255, 2, 254, 255, 128, 127};
      int ec[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
      int eo[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; e_lat = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, cout, ovf} !== 3'b000 || sum !== '0) begin
        errors++;
        $display("FAIL reset_state inst=%0d got v=%b sum=%h c=%b o=%b want all 0",
                 gi, out_valid, sum, cout, ovf);
      end
      rst = 1'b0;

      // Directed vectors (N=8 instance), with expected values given as constants.
      if (gi == 0)
        for (int i = 0; i < 9; i++) begin
          a = W'(da[i]); b = W'(db[i]); cin = 1'(dc[i]); sub = 1'(ds[i]);
          e_sum = W'(es[i]); e_cout = 1'(ec[i]); e_ovf = 1'(eo[i]);
          in_valid = 1'b1;
          send(1'b0);
        end

      // Full-rate random stream; latency is checked on every op.
      for (int i = 0; i < NR; i++) begin
        rnd_op(); in_valid = 1'b1;
        send(1'b0);
      end
      in_valid = 1'b0;
      repeat (S + 2) @(posedge clk);
      #1;

      // Backpressure: random idles and random out_ready.
      e_lat = 1'b0;
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) >= 3);
        end
        rnd_op(); in_valid = 1'b1;
        send(1'b1);
      end
      in_valid = 1'b0; out_ready = 1'b1; e_lat = 1'b1;
      repeat (S + 3) @(posedge clk);
      #1;

      // Fill the pipe with the output stalled, then reset mid-cycle.
      out_ready = 1'b0;
      repeat (S + 2) begin
        rnd_op(); in_valid = 1'b1;
        @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, cout, ovf} !== 3'b000 || sum !== '0) begin
        errors++;
        $display("FAIL reset_midstream inst=%0d got v=%b sum=%h c=%b o=%b want all 0",
                 gi, out_valid, sum, cout, ovf);
      end
      q.delete();
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        rnd_op(); in_valid = 1'b1;
        send(1'b0);
      end
      in_valid = 1'b0;
      repeat (S + 3) @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain inst=%0d got %0d pending want 0", gi, q.size());
      end
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 60000 && done != 5'h1f; t++) @(posedge clk);
    if (done != 5'h1f) begin
      errors++;
      $display("FAIL timeout got done=%b want 11111", done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
